// File: rtl/eth_pcs_tx_blk_sched.sv
// rtl/eth_pcs_tx_blk_sched.sv - 64b/66b PCS transmit block scheduler feeding a gearbox
//
// Holds one sync header + 64-bit payload and presents it to the gearbox one
// W_DATA slice at a time. When upstream has no block at a load point, an idle
// block is substituted instead. A gearbox transfer index that disagrees with
// the internal phase drops the scheduler back to alignment.
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_blk_valid/sync/data          upstream block, o_blk_ready accepts it
//   i_gb_clk_en, i_gb_trans_cnt    gearbox consume strobe and transfer index
//   o_sync_data, o_scr_data        sync header and payload slice to gearbox
//   i_clr_cnt                      clears o_idle_cnt, o_blk_cnt, o_align_err
//   o_idle_cnt, o_blk_cnt          inserted idle / accepted block counters
//   o_hdr_err, o_align_err         bad-header pulse, sticky alignment error

module eth_pcs_tx_blk_sched #(
  parameter int                W_DATA          = 32,
  parameter int                W_SYNC          = 2,
  parameter int                TRANS_PER_BLK   = 64 / W_DATA,
  parameter int                W_TRANS_PER_BLK = (TRANS_PER_BLK > 1) ? $clog2(TRANS_PER_BLK) : 1,
  parameter logic [W_SYNC-1:0] IDLE_SYNC       = 2'b01,
  parameter logic [63:0]       IDLE_DATA       = 64'h0000_0000_0000_001E
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_blk_valid,
  input  logic [W_SYNC-1:0]          i_blk_sync,
  input  logic [63:0]                i_blk_data,
  output logic                       o_blk_ready,
  input  logic                       i_gb_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0] i_gb_trans_cnt,
  output logic [W_SYNC-1:0]          o_sync_data,
  output logic [W_DATA-1:0]          o_scr_data,
  input  logic                       i_clr_cnt,
  output logic [15:0]                o_idle_cnt,
  output logic [31:0]                o_blk_cnt,
  output logic                       o_hdr_err,
  output logic                       o_align_err
);

  localparam logic ST_ALIGN = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam logic [W_TRANS_PER_BLK-1:0] LAST_PHASE = W_TRANS_PER_BLK'(TRANS_PER_BLK - 1);

  logic                       state;
  logic [W_TRANS_PER_BLK-1:0] phase;
  logic [W_SYNC-1:0]          hold_sync;
  logic [63:0]                hold_data;

  logic cnt_match;
  logic align_load;
  logic run_load;
  logic misalign;
  logic load;
  logic hdr_bad;

  always_comb begin
    cnt_match  = (i_gb_trans_cnt == phase);
    // Leaving alignment uses the gearbox's last index as the block boundary,
    // so the first transfer after it is slice 0 of a fresh block.
    align_load = (state == ST_ALIGN) && i_gb_clk_en && (i_gb_trans_cnt == LAST_PHASE);
    run_load   = (state == ST_RUN) && i_gb_clk_en && cnt_match && (phase == LAST_PHASE);
    misalign   = (state == ST_RUN) && i_gb_clk_en && !cnt_match;
    load       = align_load || run_load;
    hdr_bad    = (&i_blk_sync) || (~|i_blk_sync);
    // Reset gates ready so nothing is accepted while reset is held.
    o_blk_ready = load && !i_reset;
  end

  assign o_sync_data = hold_sync;

  // Explicit slice mux keeps out-of-range indices at zero instead of
  // reading past the payload.
  always_comb begin
    o_scr_data = '0;
    for (int i = 0; i < TRANS_PER_BLK; i++) begin
      if (i_gb_trans_cnt == W_TRANS_PER_BLK'(i)) begin
        o_scr_data = hold_data[i*W_DATA +: W_DATA];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_ALIGN;
      phase       <= '0;
      hold_sync   <= IDLE_SYNC;
      hold_data   <= IDLE_DATA;
      o_idle_cnt  <= '0;
      o_blk_cnt   <= '0;
      o_hdr_err   <= 1'b0;
      o_align_err <= 1'b0;
    end else begin
      o_hdr_err <= load && i_blk_valid && hdr_bad;

      if (load) begin
        state <= ST_RUN;
        phase <= '0;
        if (i_blk_valid) begin
          hold_sync <= i_blk_sync;
          hold_data <= i_blk_data;
          o_blk_cnt <= o_blk_cnt + 32'd1;
        end else begin
          hold_sync <= IDLE_SYNC;
          hold_data <= IDLE_DATA;
          if (o_idle_cnt != 16'hFFFF) begin
            o_idle_cnt <= o_idle_cnt + 16'd1;
          end
        end
      end else if (misalign) begin
        state       <= ST_ALIGN;
        phase       <= '0;
        hold_sync   <= IDLE_SYNC;
        hold_data   <= IDLE_DATA;
        o_align_err <= 1'b1;
      end else if ((state == ST_RUN) && i_gb_clk_en) begin
        phase <= phase + W_TRANS_PER_BLK'(1);
      end

      // Placed last so a clear overrides any same-cycle increment or set.
      if (i_clr_cnt) begin
        o_idle_cnt  <= '0;
        o_blk_cnt   <= '0;
        o_align_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_pcs_tx_blk_sched.sv
// tb/tb_eth_pcs_tx_blk_sched.sv - self-checking bench for eth_pcs_tx_blk_sched

module tb_eth_pcs_tx_blk_sched;

  localparam int W_DATA = 32;
  localparam int TPB    = 2;
  localparam int WT     = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid;
  logic [1:0]    blk_sync;
  logic [63:0]   blk_data;
  logic          blk_ready;
  logic          gb_clk_en;
  logic [WT-1:0] gb_trans_cnt;
  logic [1:0]    sync_data;
  logic [31:0]   scr_data;
  logic          clr_cnt;
  logic [15:0]   idle_cnt;
  logic [31:0]   blk_cnt;
  logic          hdr_err;
  logic          align_err;

  eth_pcs_tx_blk_sched dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_blk_valid    (blk_valid),
    .i_blk_sync     (blk_sync),
    .i_blk_data     (blk_data),
    .o_blk_ready    (blk_ready),
    .i_gb_clk_en    (gb_clk_en),
    .i_gb_trans_cnt (gb_trans_cnt),
    .o_sync_data    (sync_data),
    .o_scr_data     (scr_data),
    .i_clr_cnt      (clr_cnt),
    .o_idle_cnt     (idle_cnt),
    .o_blk_cnt      (blk_cnt),
    .o_hdr_err      (hdr_err),
    .o_align_err    (align_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: what block is on the wire, where we are in it, counters.
  bit          m_run;
  int          m_pos;
  logic [1:0]  m_sync;
  logic [63:0] m_data;
  int          m_idle;
  logic [31:0] m_blk;
  bit          m_align;
  bit          m_hdr;
  logic [31:0] last_scr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_pos   = 0;
    m_sync  = 2'b01;
    m_data  = 64'h0000_0000_0000_001E;
    m_idle  = 0;
    m_blk   = 0;
    m_align = 0;
    m_hdr   = 0;
  endtask

  function automatic logic [31:0] slice_of(input logic [63:0] d, input int idx);
    logic [63:0] sh;
    sh = d >> (idx * W_DATA);
    return sh[31:0];
  endfunction

  task automatic step(input bit ce, input int cnt, input bit v, input logic [1:0] s,
                      input logic [63:0] d, input bit clr);
    bit exp_ready;
    bit loaded;
    @(negedge clk);
    gb_clk_en    = ce;
    gb_trans_cnt = WT'(cnt);
    blk_valid    = v;
    blk_sync     = s;
    blk_data     = d;
    clr_cnt      = clr;
    #1;
    exp_ready = ce && (m_run ? (cnt == m_pos && m_pos == TPB - 1) : (cnt == TPB - 1));
    chk("ready", blk_ready, exp_ready);
    chk("sync_pre", sync_data, m_sync);
    chk("scr_pre", scr_data, slice_of(m_data, cnt));
    last_scr = scr_data;
    @(posedge clk);
    loaded = 0;
    m_hdr  = 0;
    if (ce) begin
      if (!m_run) begin
        if (cnt == TPB - 1) begin
          loaded = 1;
          m_run  = 1;
          m_pos  = 0;
        end
      end else if (cnt != m_pos) begin
        m_align = 1;
        m_run   = 0;
        m_pos   = 0;
        m_sync  = 2'b01;
        m_data  = 64'h0000_0000_0000_001E;
      end else begin
        if (m_pos == TPB - 1) loaded = 1;
        m_pos = (m_pos + 1) % TPB;
      end
    end
    if (loaded) begin
      if (v) begin
        m_sync = s;
        m_data = d;
        m_blk  = m_blk + 1;
        m_hdr  = (s == 2'b00) || (s == 2'b11);
      end else begin
        m_sync = 2'b01;
        m_data = 64'h0000_0000_0000_001E;
        if (m_idle < 65535) m_idle++;
      end
    end
    if (clr) begin
      m_idle  = 0;
      m_blk   = 0;
      m_align = 0;
    end
    #1;
    chk("idle_cnt", idle_cnt, m_idle);
    chk("blk_cnt", blk_cnt, m_blk);
    chk("hdr_err", hdr_err, m_hdr);
    chk("align_err", align_err, m_align);
    chk("sync_post", sync_data, m_sync);
  endtask

  initial begin
    bit          ce;
    int          cnt;
    bit          v;
    logic [63:0] d;

    rst          = 1'b1;
    blk_valid    = 1'b0;
    blk_sync     = 2'b00;
    blk_data     = '0;
    gb_clk_en    = 1'b0;
    gb_trans_cnt = '0;
    clr_cnt      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", blk_ready, 1'b0);
    chk("rst_sync", sync_data, 2'b01);
    chk("rst_scr0", scr_data, 32'h0000_001E);
    chk("rst_idle", idle_cnt, 16'd0);
    chk("rst_blk", blk_cnt, 32'd0);
    chk("rst_hdr", hdr_err, 1'b0);
    chk("rst_align", align_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Alignment then two accepted blocks
    step(1, 0, 1, 2'b10, 64'hA5A5_0000_5A5A_FFFF, 0);
    step(1, 1, 1, 2'b10, 64'hA5A5_0000_5A5A_FFFF, 0);
    chk("req036_blk1", blk_cnt, 32'd1);
    step(1, 0, 1, 2'b10, 64'hA5A5_0000_5A5A_FFFF, 0);
    chk("req036_lo", last_scr, 32'h5A5A_FFFF);
    step(1, 1, 1, 2'b10, 64'hA5A5_0000_5A5A_FFFF, 0);
    chk("req036_hi", last_scr, 32'hA5A5_0000);
    chk("req036_blk2", blk_cnt, 32'd2);

    // Three idle insertions
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 2'b10, 64'h1111_2222_3333_4444, 0);
      step(1, 1, 0, 2'b10, 64'h1111_2222_3333_4444, 0);
    end
    chk("req037_idle", idle_cnt, 16'd3);
    chk("req037_sync", sync_data, 2'b01);
    step(1, 0, 0, 2'b10, 64'h0, 0);
    chk("req037_slice0", last_scr, 32'h0000_001E);

    // Stall at phase 1, then load on resume
    step(0, 1, 1, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 0);
    chk("req038_stall_idle", idle_cnt, 16'd3);
    step(1, 1, 1, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 0);

    // Bad sync header passes through with a pulse
    step(1, 0, 1, 2'b11, 64'h0123_4567_89AB_CDEF, 0);
    step(1, 1, 1, 2'b11, 64'h0123_4567_89AB_CDEF, 0);
    chk("req039_hdr", hdr_err, 1'b1);
    step(1, 0, 1, 2'b10, 64'h0, 0);
    chk("req039_hdr_clear", hdr_err, 1'b0);
    chk("req039_slice", last_scr, 32'h89AB_CDEF);

    // Misalignment, re-align, then clear
    step(1, 0, 1, 2'b10, 64'h0, 0);
    chk("req040_align", align_err, 1'b1);
    chk("req040_idle_sync", sync_data, 2'b01);
    step(1, 0, 1, 2'b10, 64'h7777_8888_9999_AAAA, 0);
    step(1, 1, 1, 2'b10, 64'h7777_8888_9999_AAAA, 0);
    step(0, 0, 1, 2'b10, 64'h0, 1);
    chk("req040_clr", align_err, 1'b0);

    // Randomized traffic with occasional stalls, misalignments and clears
    for (int i = 0; i < 400; i++) begin
      ce  = ($urandom_range(0, 3) != 0);
      if (m_run) cnt = ($urandom_range(0, 19) == 0) ? (1 - m_pos) : m_pos;
      else       cnt = $urandom_range(0, 1);
      v   = m_run ? 1'($urandom_range(0, 1)) : 1'b1;
      d   = {$urandom, $urandom};
      step(ce, cnt, v, 2'($urandom_range(0, 3)), d, ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-block
    step(1, 0, 1, 2'b10, 64'hFEED_FACE_0BAD_F00D, 0);
    step(1, 1, 1, 2'b10, 64'hFEED_FACE_0BAD_F00D, 0);
    @(negedge clk);
    gb_clk_en    = 1'b1;
    gb_trans_cnt = 1'b1;
    blk_valid    = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("req041_sync", sync_data, 2'b01);
    chk("req041_blk", blk_cnt, 32'd0);
    chk("req041_idle", idle_cnt, 16'd0);
    chk("req041_ready", blk_ready, 1'b0);
    gb_trans_cnt = 1'b0;
    #1;
    chk("req041_scr", scr_data, 32'h0000_001E);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 1, 2'b10, 64'h5555_6666_7777_8888, 0);
    step(1, 1, 1, 2'b10, 64'h5555_6666_7777_8888, 0);
    step(1, 0, 1, 2'b10, 64'h0, 0);
    chk("req035_first", last_scr, 32'h7777_8888);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_pcs_tx_blk_sched.md
ETH_PCS_TX_BLK_SCHED -- requirements
Module: eth_pcs_tx_blk_sched

Interface
REQ-001 Parameter W_DATA, default 32, gearbox transfer width in bits; legal values 16, 32, 64.
REQ-002 Parameter W_SYNC, default 2, sync header width.
REQ-003 Parameter TRANS_PER_BLK, default 64/W_DATA, transfers per 64-bit payload; W_TRANS_PER_BLK = max(1, clog2(TRANS_PER_BLK)).
REQ-004 Parameter IDLE_SYNC, default 2'b01, sync header of the inserted idle block.
REQ-005 Parameter IDLE_DATA, default 64'h0000_0000_0000_001E, payload of the inserted idle block.
REQ-006 i_clk  input  1  sole clock, all state on rising edge.
REQ-007 i_reset  input  1  asynchronous, active-high reset.
REQ-008 i_blk_valid  input  1  upstream block available.
REQ-009 i_blk_sync  input  W_SYNC  upstream sync header.
REQ-010 i_blk_data  input  64  upstream scrambled payload.
REQ-011 o_blk_ready  output  1  upstream block accepted this cycle when i_blk_valid=1.
REQ-012 i_gb_clk_en  input  1  gearbox consumes a transfer this cycle.
REQ-013 i_gb_trans_cnt  input  W_TRANS_PER_BLK  gearbox transfer index within block.
REQ-014 o_sync_data  output  W_SYNC  sync header to gearbox.
REQ-015 o_scr_data  output  W_DATA  payload slice to gearbox.
REQ-016 i_clr_cnt  input  1  synchronous clear of statistics counters.
REQ-017 o_idle_cnt  output  16  inserted idle blocks, saturating.
REQ-018 o_blk_cnt  output  32  accepted upstream blocks, wrapping.
REQ-019 o_hdr_err  output  1  one-cycle pulse: accepted block had sync header 2'b00 or 2'b11.
REQ-020 o_align_err  output  1  sticky: gearbox transfer index disagreed with internal phase.

Function
REQ-021 Hold register (sync + 64-bit payload) shall hold the block currently being transferred.
REQ-022 o_scr_data shall equal hold payload bits [i_gb_trans_cnt*W_DATA +: W_DATA], combinational from i_gb_trans_cnt (zero latency).
REQ-023 o_sync_data shall equal the hold sync header at all times.
REQ-024 FSM states: ALIGN, RUN.
REQ-025 ALIGN: hold register = idle block; o_blk_ready=0; transition to RUN on i_gb_clk_en=1 and i_gb_trans_cnt=TRANS_PER_BLK-1, loading the next block per REQ-027/028 that cycle; internal phase set to 0.
REQ-026 RUN: internal phase increments modulo TRANS_PER_BLK on each i_gb_clk_en=1 cycle; holds when i_gb_clk_en=0.
REQ-027 RUN load point: i_gb_clk_en=1 and phase=TRANS_PER_BLK-1; o_blk_ready=1 only at load point, 0 otherwise (combinational).
REQ-028 At load point with i_blk_valid=1: hold register loads i_blk_sync/i_blk_data; o_blk_cnt increments; o_hdr_err pulses next cycle if header invalid; block passed unchanged.
REQ-029 At load point with i_blk_valid=0: hold register loads IDLE_SYNC/IDLE_DATA; o_idle_cnt increments, saturating at 16'hFFFF.
REQ-030 RUN with i_gb_clk_en=1 and i_gb_trans_cnt != phase: o_align_err set, FSM to ALIGN, hold loads idle block; no block accepted that cycle.
REQ-031 i_gb_clk_en=0 (gearbox stall): hold register, phase, counters unchanged; o_blk_ready=0.
REQ-032 i_clr_cnt=1 clears o_idle_cnt, o_blk_cnt, o_align_err; clear wins over same-cycle increment/set.
REQ-033 TRANS_PER_BLK=1: every i_gb_clk_en=1 cycle in RUN is a load point.

Reset
REQ-034 On i_reset=1 (immediate, asynchronous): FSM=ALIGN, phase=0, hold=idle block, counters=0, o_hdr_err=0, o_align_err=0, o_blk_ready=0.
REQ-035 Reset deassertion mid-stream shall restart alignment; no partial block shall be emitted after reset.

Verification
REQ-036 Reset, then gearbox cnt 0,1,0,1 with clk_en=1, valid=1 data 64'hA5A5_0000_5A5A_FFFF sync 2'b10 -> ready=1 only at cnt 1 cycles; after first load, scr_data=32'h5A5A_FFFF at cnt0, 32'hA5A5_0000 at cnt1; blk_cnt=1 then 2.
REQ-037 RUN, valid=0 for three load points -> three idle blocks (sync 2'b01, slices 32'h0000_001E, 32'h0), idle_cnt=3, blk_cnt unchanged.
REQ-038 clk_en=0 for one cycle at phase 1 -> ready=0, outputs and counters frozen; load occurs at next clk_en=1 cycle.
REQ-039 Accept block with sync 2'b11 -> data passed unchanged, o_hdr_err one-cycle pulse, blk_cnt increments.
REQ-040 In RUN force trans_cnt=0 when phase=1 with clk_en=1 -> align_err=1, idle output, re-align at next cnt=1; i_clr_cnt clears align_err.
REQ-041 Assert i_reset mid-block asynchronously -> outputs idle block and counters 0 before next clock edge.
